// File: rtl/conv_layer_input_interface.sv
// Conv-layer input responder: fills a KERNEL_SIZE-row line buffer from the image ROM
// on controller commands and presents a KERNEL_SIZE x ARRAY_SIZE window to the PE array.
module conv_layer_input_interface #(
    parameter int KERNEL_SIZE = 3,
    parameter int IMAGE_SIZE  = 8,
    parameter int ARRAY_SIZE  = 6,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 6,
    parameter int ROM_DEPTH   = 64
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         enable,
    input  logic [1:0]                                   input_interface_cmd,
    output logic [1:0]                                   input_interface_ack,
    output logic [ADDR_WIDTH-1:0]                        rom_addr,
    output logic                                         rom_rd_en,
    input  logic [DATA_WIDTH-1:0]                        rom_data,
    output logic [KERNEL_SIZE*ARRAY_SIZE*DATA_WIDTH-1:0] array_data,
    output logic                                         array_valid,
    output logic                                         busy,
    output logic                                         frame_end,
    output logic                                         cmd_err
);
    localparam int NRD      = KERNEL_SIZE * IMAGE_SIZE;
    localparam int CW       = $clog2(NRD + 1);
    localparam int CLW      = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int KRW      = $clog2(KERNEL_SIZE + 1);
    localparam int COW      = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int RW       = $clog2(IMAGE_SIZE + KERNEL_SIZE + 1);
    localparam int ROM_ROWS = ROM_DEPTH / IMAGE_SIZE;
    localparam int LAST_ROW = (ROM_ROWS < IMAGE_SIZE) ? ROM_ROWS : IMAGE_SIZE;

    localparam logic [1:0] CMD_IDLE = 2'd0, CMD_PRELOAD = 2'd1, CMD_SHIFT = 2'd2, CMD_LOAD = 2'd3;
    localparam logic [1:0] ACK_IDLE = 2'd0, ACK_PRELOAD_FIN = 2'd1, ACK_SHIFT_FIN = 2'd2,
                           ACK_LOAD_FIN = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_ACK} state_t;
    typedef logic [IMAGE_SIZE-1:0][DATA_WIDTH-1:0] row_t;

    state_t                             state_q, state_d;
    logic [1:0]                         ack_q, ack_d;
    logic [ADDR_WIDTH-1:0]              addr_q, addr_d;
    logic                               rd_en_q, rd_en_d;
    logic                               cap_en_q, cap_en_d;
    logic [CW-1:0]                      rd_cnt_q, rd_cnt_d, rd_total_q, rd_total_d;
    logic [CW-1:0]                      cap_cnt_q, cap_cnt_d;
    logic [KRW-1:0]                     cap_row_q, cap_row_d;
    logic [CLW-1:0]                     cap_col_q, cap_col_d;
    logic                               op_load_q, op_load_d;
    logic [RW-1:0]                      row_base_q, row_base_d, next_row;
    logic [COW-1:0]                     col_off_q, col_off_d;
    logic [KERNEL_SIZE-1:0][IMAGE_SIZE-1:0][DATA_WIDTH-1:0] line_q, line_d;
    row_t                               stage_q, stage_d;
    logic                               valid_q, valid_d, busy_q, busy_d;
    logic                               fe_q, fe_d, err_q, err_d;

    assign next_row = row_base_q + RW'(KERNEL_SIZE);

    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        addr_d     = addr_q;
        rd_en_d    = 1'b0;
        cap_en_d   = rd_en_q;  // ROM data shows up one cycle after the strobe
        rd_cnt_d   = rd_cnt_q;
        rd_total_d = rd_total_q;
        cap_cnt_d  = cap_cnt_q;
        cap_row_d  = cap_row_q;
        cap_col_d  = cap_col_q;
        op_load_d  = op_load_q;
        row_base_d = row_base_q;
        col_off_d  = col_off_q;
        line_d     = line_q;
        stage_d    = stage_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        fe_d       = fe_q;
        err_d      = err_q;

        // Captures are independent of enable so an issued read is never lost.
        if (cap_en_q) begin
            if (op_load_q) stage_d[cap_col_q] = rom_data;
            else           line_d[cap_row_q][cap_col_q] = rom_data;
            cap_cnt_d = cap_cnt_q + CW'(1);
            if (cap_col_q == CLW'(IMAGE_SIZE - 1)) begin
                cap_col_d = '0;
                cap_row_d = cap_row_q + KRW'(1);
            end else begin
                cap_col_d = cap_col_q + CLW'(1);
            end
        end

        if (input_interface_cmd != CMD_IDLE && state_q != S_IDLE) err_d = 1'b1;

        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    case (input_interface_cmd)
                        CMD_PRELOAD: begin
                            row_base_d = '0;
                            col_off_d  = '0;
                            valid_d    = 1'b0;
                            fe_d       = 1'b0;
                            busy_d     = 1'b1;
                            op_load_d  = 1'b0;
                            addr_d     = '0;
                            rd_en_d    = 1'b1;
                            rd_cnt_d   = CW'(1);
                            rd_total_d = CW'(NRD);
                            cap_cnt_d  = '0;
                            cap_row_d  = '0;
                            cap_col_d  = '0;
                            state_d    = S_READ;
                        end
                        CMD_SHIFT: begin
                            col_off_d = (col_off_q == COW'(KERNEL_SIZE - 1)) ? '0 : col_off_q + COW'(1);
                            ack_d     = ACK_SHIFT_FIN;
                            busy_d    = 1'b1;
                            state_d   = S_ACK;
                        end
                        CMD_LOAD: begin
                            busy_d = 1'b1;
                            if (next_row < RW'(LAST_ROW)) begin
                                valid_d    = 1'b0;
                                op_load_d  = 1'b1;
                                addr_d     = ADDR_WIDTH'(next_row) * ADDR_WIDTH'(IMAGE_SIZE);
                                rd_en_d    = 1'b1;
                                rd_cnt_d   = CW'(1);
                                rd_total_d = CW'(IMAGE_SIZE);
                                cap_cnt_d  = '0;
                                cap_row_d  = '0;
                                cap_col_d  = '0;
                                state_d    = S_READ;
                            end else begin
                                fe_d    = 1'b1;
                                ack_d   = ACK_LOAD_FIN;
                                state_d = S_ACK;
                            end
                        end
                        default: ;
                    endcase
                end
                S_READ: begin
                    if (rd_cnt_q == rd_total_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d   = addr_q + ADDR_WIDTH'(1);
                        rd_en_d  = 1'b1;
                        rd_cnt_d = rd_cnt_q + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (cap_cnt_d == rd_total_q) begin
                        valid_d = 1'b1;
                        state_d = S_ACK;
                        if (op_load_q) begin
                            // Scroll all rows up and commit the staged row in one edge.
                            line_d[KERNEL_SIZE-2:0] = line_q[KERNEL_SIZE-1:1];
                            line_d[KERNEL_SIZE-1]   = stage_d;
                            row_base_d = row_base_q + RW'(1);
                            col_off_d  = '0;
                            ack_d      = ACK_LOAD_FIN;
                        end else begin
                            ack_d = ACK_PRELOAD_FIN;
                        end
                    end
                end
                S_ACK: begin
                    ack_d   = ACK_IDLE;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ack_q      <= ACK_IDLE;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            cap_en_q   <= 1'b0;
            rd_cnt_q   <= '0;
            rd_total_q <= '0;
            cap_cnt_q  <= '0;
            cap_row_q  <= '0;
            cap_col_q  <= '0;
            op_load_q  <= 1'b0;
            row_base_q <= '0;
            col_off_q  <= '0;
            line_q     <= '0;
            stage_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            fe_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
            cap_en_q   <= cap_en_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_total_q <= rd_total_d;
            cap_cnt_q  <= cap_cnt_d;
            cap_row_q  <= cap_row_d;
            cap_col_q  <= cap_col_d;
            op_load_q  <= op_load_d;
            row_base_q <= row_base_d;
            col_off_q  <= col_off_d;
            line_q     <= line_d;
            stage_q    <= stage_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            fe_q       <= fe_d;
            err_q      <= err_d;
        end
    end

    // A pending ack is only presented on enabled cycles.
    assign input_interface_ack = enable ? ack_q : ACK_IDLE;
    assign rom_addr    = addr_q;
    assign rom_rd_en   = rd_en_q;
    assign array_valid = valid_q;
    assign busy        = busy_q;
    assign frame_end   = fe_q;
    assign cmd_err     = err_q;

    for (genvar r = 0; r < KERNEL_SIZE; r++) begin : g_row
        for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
            logic [CLW-1:0] sel;
            assign sel = CLW'(col_off_q) + CLW'(c);
            assign array_data[(r*ARRAY_SIZE+c)*DATA_WIDTH +: DATA_WIDTH] = line_q[r][sel];
        end
    end
endmodule

// File: doc/conv_layer_input_interface.md
Name: conv_layer_input_interface

Overview:
- Responder end of the conv-layer input command/ack protocol; executes controller commands and reports completion.
- PRELOAD fills a KERNEL_SIZE-row image line buffer from the image ROM. SHIFT advances the window column offset. LOAD scrolls in the next image row.
- Presents a KERNEL_SIZE x ARRAY_SIZE pixel window to the PE array.

Parameters:
- KERNEL_SIZE, 3, window rows; column-offset modulus.
- IMAGE_SIZE, 8, image width/height in pixels; must equal ARRAY_SIZE+KERNEL_SIZE-1.
- ARRAY_SIZE, 6, window columns presented per row.
- DATA_WIDTH, 8, pixel width.
- ADDR_WIDTH, 6, ROM address width.
- ROM_DEPTH, 64, ROM words (IMAGE_SIZE*IMAGE_SIZE).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  1 = advance; 0 = freeze FSM and counters.
- input_interface_cmd  in  2  0 IDLE, 1 PRELOAD, 2 SHIFT, 3 LOAD; one-cycle pulse.
- input_interface_ack  out  2  0 IDLE, 1 PRELOAD_FIN, 2 SHIFT_FIN, 3 LOAD_FIN; one-cycle pulse.
- rom_addr  out  ADDR_WIDTH  image ROM read address.
- rom_rd_en  out  1  ROM read strobe; data valid on rom_data exactly 1 cycle later.
- rom_data  in  DATA_WIDTH  ROM read data.
- array_data  out  KERNEL_SIZE*ARRAY_SIZE*DATA_WIDTH  window; pixel (r,c) at slice index r*ARRAY_SIZE+c = buf[r][col_off+c].
- array_valid  out  1  window contents valid.
- busy  out  1  command in progress.
- frame_end  out  1  sticky: LOAD requested past the last image row.
- cmd_err  out  1  sticky: non-IDLE command received while busy.

Behaviour:
- Reset (any time, including mid-command): FSM=IDLE; ack=0; rom_addr=0; rom_rd_en=0; row_base=0; col_off=0; line buffer cleared to 0; array_valid=0; busy=0; frame_end=0; cmd_err=0. In-flight ROM data is discarded.
- FSM states: IDLE, READ (issue ROM reads), DRAIN (capture last datum), ACK (drive ack for 1 cycle). Return to IDLE after ACK.
- Commands are sampled in IDLE only, and only when enable=1. A non-IDLE command in any other state is ignored and sets cmd_err.
- CMD IDLE: no action.
- PRELOAD:
  - Sets row_base=0, col_off=0, array_valid=0.
  - Issues KERNEL_SIZE*IMAGE_SIZE reads on consecutive cycles, addresses 0..23 (defaults) in order.
  - Datum i is written to buf[i/IMAGE_SIZE][i%IMAGE_SIZE].
  - ACK_PRELOAD_FIN is asserted the cycle after the last datum is captured. With defaults: cmd sampled at edge 0 -> rd_en high for cycles 1..24 -> data captured at edges 2..25 -> ack high for cycle 26.
  - array_valid=1 together with the ack. Clears frame_end.
- SHIFT:
  - col_off <= (col_off==KERNEL_SIZE-1) ? 0 : col_off+1, updated at the sampling edge.
  - ACK_SHIFT_FIN is high the following cycle (latency 1). array_valid unchanged.
- LOAD:
  - next_row = row_base+KERNEL_SIZE.
  - If next_row < IMAGE_SIZE:
    - array_valid=0.
    - Read next_row*IMAGE_SIZE .. +IMAGE_SIZE-1 on consecutive cycles.
    - On the edge the last datum is captured: buf[0] <= buf[1] ... buf[K-2] <= buf[K-1], and buf[K-1] <= new row, atomically. Row assembly uses a staging register.
    - row_base++; col_off=0.
    - ACK_LOAD_FIN the next cycle; array_valid=1 with the ack.
    - Latency with defaults: ack in cycle 10 after the sampling edge.
  - If next_row >= IMAGE_SIZE: no reads, buffer unchanged, frame_end set, ACK_LOAD_FIN after 1 cycle.
- enable=0:
  - FSM, counters and rom_addr hold; rom_rd_en=0.
  - A read already issued is captured at the next edge regardless of enable.
  - A pending ack is held, not pulsed, until enable returns; then the ack pulses for exactly one enabled cycle.
- busy=1 from the sampling edge through the ack cycle inclusive.
- rom_addr arithmetic: row*IMAGE_SIZE+col computed in ADDR_WIDTH bits. No wrap occurs for legal parameters.

Test Plan:
- ROM[a]=a; reset, PRELOAD -> rd_en for 24 cycles at addresses 0..23; ack=1 exactly once at cycle 26; array_data row0 = 0..5, row1 = 8..13, row2 = 16..21; array_valid=1.
- After PRELOAD, SHIFT x3 -> each ack=2 one cycle after cmd; col_off sequence 1,2,0; row0 window = 1..6, then 2..7, then 0..5.
- After PRELOAD, LOAD -> reads at addresses 24..31; ack=3; rows become 8..13, 16..21, 24..29; col_off=0. Further LOADs up to row 7 succeed; the 6th LOAD gives an immediate ack=3 with no rd_en and frame_end=1; the next PRELOAD clears frame_end.
- SHIFT issued during PRELOAD reads -> ignored, cmd_err=1; PRELOAD timing and data unchanged.
- enable=0 for 5 cycles mid-LOAD -> rd_en=0 and address held; total latency extended by 5 cycles; final buffer contents correct; a single ack pulse.
- rst_n low mid-PRELOAD (cycle 10) -> all outputs at reset values immediately; after release, a fresh PRELOAD completes normally.
